// File: rtl/vstore_mem_writer.sv
// Vector store memory writer.
// Turns the in-order stream of VRF store words into aligned memory write
// requests, masks the final partial word, counts outstanding write acks and
// reports each completed store instruction to the committer.
module vstore_mem_writer #(
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned VlWidth        = 16,
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_base_addr_i,
  input  logic [VlWidth-1:0]     req_vlB_i,
  input  logic [IdWidth-1:0]     req_insn_id_i,
  input  logic                   store_op_valid_i,
  output logic                   store_op_gnt_o,
  input  logic [DataWidth-1:0]   store_op_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_be_o,
  input  logic                   mem_ack_i,
  output logic                   done_o,
  output logic [IdWidth-1:0]     done_insn_id_o,
  input  logic                   done_gnt_i
);

  localparam int unsigned WordB = DataWidth / 8;
  localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);

  localparam logic [VlWidth-1:0]   WordBRem  = VlWidth'(WordB);
  localparam logic [AddrWidth-1:0] WordBAddr = AddrWidth'(WordB);
  localparam logic [OutW-1:0]      MaxOut    = OutW'(MaxOutstanding);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN,
    DONE
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [VlWidth-1:0]   rem_q;
  logic [OutW-1:0]      out_q;
  logic [OutW-1:0]      out_d;
  logic [IdWidth-1:0]   id_q;
  logic                 in_send;
  logic                 xfer;

  assign in_send        = (state_q == SEND);
  assign req_ready_o    = (state_q == IDLE);
  assign done_o         = (state_q == DONE);
  assign done_insn_id_o = id_q;

  // Request/grant handshake, write payload and next outstanding count.
  // Credits are judged on the registered count, so an ack arriving while
  // full only frees a slot from the following cycle.
  always_comb begin
    mem_req_o      = in_send && store_op_valid_i && (out_q < MaxOut);
    xfer           = mem_req_o && mem_gnt_i;
    store_op_gnt_o = xfer;
    mem_addr_o     = in_send ? addr_q : '0;
    mem_wdata_o    = in_send ? store_op_i : '0;
    mem_be_o       = '0;
    for (int unsigned i = 0; i < WordB; i++) begin
      mem_be_o[i] = in_send && (VlWidth'(i) < rem_q);
    end
    unique case ({xfer, mem_ack_i})
      2'b10:   out_d = out_q + OutW'(1);
      2'b01:   out_d = (out_q == '0) ? '0 : out_q - OutW'(1);
      default: out_d = out_q;
    endcase
  end

  // Instruction sequencing: address/remaining-byte tracking and state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      out_q   <= '0;
    end else begin
      out_q <= out_d;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q  <= req_base_addr_i;
            rem_q   <= req_vlB_i;
            state_q <= (req_vlB_i == '0) ? DONE : SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            addr_q <= addr_q + WordBAddr;
            rem_q  <= (rem_q > WordBRem) ? rem_q - WordBRem : '0;
            if (rem_q <= WordBRem) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_d == '0) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (done_gnt_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Instruction id capture; only meaningful while done_o is high.
  always_ff @(posedge clk_i) begin
    if ((state_q == IDLE) && req_valid_i) begin
      id_q <= req_insn_id_i;
    end
  end

`ifndef SYNTHESIS
  // An ack with nothing outstanding is an upstream protocol violation.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(mem_ack_i && (out_q == '0)))
        else $error("vstore_mem_writer: mem_ack_i with no outstanding writes");
    end
  end
`endif

endmodule
